// File: rtl/rename_n.sv
// N-wide register-rename stage: owns the RAT, allocates ROB tags, resolves
// same-group dependencies and commit bypass, and registers a compacted output group.

// Producer lookup for one source operand of one output slot.
module rename_n_lookup #(
    parameter int WIDTH        = 2,
    parameter int AW           = 5,
    parameter int TAG_WIDTH    = 6,
    parameter int COMMIT_PORTS = 2,
    parameter int SLOT         = 0
) (
    input  logic [AW-1:0]                           i_rs,
    input  logic [WIDTH-1:0][AW-1:0]                i_rd,
    input  logic [WIDTH-1:0]                        i_has_rd,
    input  logic [WIDTH-1:0][TAG_WIDTH-1:0]         i_dest_tag,
    input  logic [TAG_WIDTH-1:0]                    i_rat_tag,
    input  logic                                    i_rat_busy,
    input  logic [COMMIT_PORTS-1:0]                 i_commit_valid,
    input  logic [COMMIT_PORTS-1:0][TAG_WIDTH-1:0]  i_commit_tag,
    output logic [TAG_WIDTH-1:0]                    o_tag,
    output logic                                    o_busy
);
    logic                 w_fwd;
    logic [TAG_WIDTH-1:0] w_fwd_tag;
    logic                 w_commit_hit;

    always_comb begin
        w_fwd        = 1'b0;
        w_fwd_tag    = '0;
        w_commit_hit = 1'b0;
        // Older slots are always granted when this slot is; the youngest match wins.
        for (int j = 0; j < WIDTH; j++) begin
            if (j < SLOT && i_has_rd[j] && i_rd[j] == i_rs && i_rd[j] != '0) begin
                w_fwd     = 1'b1;
                w_fwd_tag = i_dest_tag[j];
            end
        end
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            if (i_commit_valid[p] && i_commit_tag[p] == i_rat_tag)
                w_commit_hit = 1'b1;
        end
    end

    always_comb begin
        o_tag  = i_rat_tag;
        o_busy = i_rat_busy;
        if (i_rs == '0) begin
            o_tag  = '0;
            o_busy = 1'b0;
        end else if (w_fwd) begin
            o_tag  = w_fwd_tag;
            o_busy = 1'b1;
        end else if (i_rat_busy && w_commit_hit) begin
            o_busy = 1'b0;
        end
    end
endmodule

module rename_n #(
    parameter int WIDTH        = 2,
    parameter int ARCH_REGS    = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int COMMIT_PORTS = 2,
    parameter int PAYLOAD_W    = 64,
    localparam int AW          = $clog2(ARCH_REGS),
    localparam int CW          = $clog2(WIDTH + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [WIDTH-1:0]                        in_valid,
    output logic                                    in_ready,
    input  logic [WIDTH-1:0][AW-1:0]                in_rs1,
    input  logic [WIDTH-1:0][AW-1:0]                in_rs2,
    input  logic [WIDTH-1:0][AW-1:0]                in_rd,
    input  logic [WIDTH-1:0]                        in_has_rd,
    input  logic [WIDTH-1:0][PAYLOAD_W-1:0]         in_payload,
    output logic [CW-1:0]                           rob_alloc_req,
    input  logic [CW-1:0]                           rob_alloc_gnt,
    input  logic [WIDTH-1:0][TAG_WIDTH-1:0]         rob_tags,
    input  logic [COMMIT_PORTS-1:0]                 commit_valid,
    input  logic [COMMIT_PORTS-1:0][AW-1:0]         commit_rd,
    input  logic [COMMIT_PORTS-1:0][TAG_WIDTH-1:0]  commit_tag,
    output logic [WIDTH-1:0]                        out_valid,
    input  logic                                    out_ready,
    output logic [WIDTH-1:0][TAG_WIDTH-1:0]         out_rs1_tag,
    output logic [WIDTH-1:0][TAG_WIDTH-1:0]         out_rs2_tag,
    output logic [WIDTH-1:0]                        out_rs1_busy,
    output logic [WIDTH-1:0]                        out_rs2_busy,
    output logic [WIDTH-1:0][TAG_WIDTH-1:0]         out_dest_tag,
    output logic [WIDTH-1:0][PAYLOAD_W-1:0]         out_payload
);
    logic [TAG_WIDTH-1:0] r_rat_tag [ARCH_REGS];
    logic [ARCH_REGS-1:0] r_rat_busy;
    logic [TAG_WIDTH-1:0] w_tag_nxt [ARCH_REGS];
    logic [ARCH_REGS-1:0] w_busy_nxt;
    logic [CW-1:0]        r_done_cnt;

    logic [WIDTH-1:0]                r_out_valid;
    logic [WIDTH-1:0][TAG_WIDTH-1:0] r_out_rs1_tag, r_out_rs2_tag, r_out_dest_tag;
    logic [WIDTH-1:0]                r_out_rs1_busy, r_out_rs2_busy;
    logic [WIDTH-1:0][PAYLOAD_W-1:0] r_out_payload;

    logic [CW-1:0] w_valid_cnt, w_remaining, w_g;
    logic          w_accept, w_go;

    logic [WIDTH-1:0]                w_slot_vld, w_s_has_rd;
    logic [WIDTH-1:0][AW-1:0]        w_s_rs1, w_s_rs2, w_s_rd;
    logic [WIDTH-1:0][PAYLOAD_W-1:0] w_s_payload;
    logic [WIDTH-1:0][TAG_WIDTH-1:0] w_rat_tag1, w_rat_tag2, w_rs1_tag, w_rs2_tag;
    logic [WIDTH-1:0]                w_rat_busy1, w_rat_busy2, w_rs1_busy, w_rs2_busy;

    always_comb begin
        w_valid_cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            w_valid_cnt = w_valid_cnt + CW'(in_valid[i]);
    end

    assign w_remaining   = w_valid_cnt - r_done_cnt;
    assign w_accept      = !(|r_out_valid) || out_ready;
    assign w_go          = w_accept && !flush;
    assign rob_alloc_req = w_go ? w_remaining : '0;
    assign w_g           = w_go ? rob_alloc_gnt : '0;
    assign in_ready      = !flush && (w_remaining == '0 || (w_accept && w_g == w_remaining));

    // Compact the held group: decode lane done_cnt+k feeds output slot k.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_slot_vld[k]  = (k < int'(w_g));
            w_s_rs1[k]     = '0;
            w_s_rs2[k]     = '0;
            w_s_rd[k]      = '0;
            w_s_has_rd[k]  = 1'b0;
            w_s_payload[k] = '0;
            for (int l = 0; l < WIDTH; l++) begin
                if (l == int'(r_done_cnt) + k) begin
                    w_s_rs1[k]     = in_rs1[l];
                    w_s_rs2[k]     = in_rs2[l];
                    w_s_rd[k]      = in_rd[l];
                    w_s_has_rd[k]  = in_has_rd[l];
                    w_s_payload[k] = in_payload[l];
                end
            end
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_slot
        assign w_rat_tag1[k]  = r_rat_tag[w_s_rs1[k]];
        assign w_rat_busy1[k] = r_rat_busy[w_s_rs1[k]];
        assign w_rat_tag2[k]  = r_rat_tag[w_s_rs2[k]];
        assign w_rat_busy2[k] = r_rat_busy[w_s_rs2[k]];

        rename_n_lookup #(
            .WIDTH(WIDTH), .AW(AW), .TAG_WIDTH(TAG_WIDTH),
            .COMMIT_PORTS(COMMIT_PORTS), .SLOT(k)
        ) u_rs1 (
            .i_rs(w_s_rs1[k]), .i_rd(w_s_rd), .i_has_rd(w_s_has_rd),
            .i_dest_tag(rob_tags), .i_rat_tag(w_rat_tag1[k]),
            .i_rat_busy(w_rat_busy1[k]), .i_commit_valid(commit_valid),
            .i_commit_tag(commit_tag), .o_tag(w_rs1_tag[k]), .o_busy(w_rs1_busy[k])
        );

        rename_n_lookup #(
            .WIDTH(WIDTH), .AW(AW), .TAG_WIDTH(TAG_WIDTH),
            .COMMIT_PORTS(COMMIT_PORTS), .SLOT(k)
        ) u_rs2 (
            .i_rs(w_s_rs2[k]), .i_rd(w_s_rd), .i_has_rd(w_s_has_rd),
            .i_dest_tag(rob_tags), .i_rat_tag(w_rat_tag2[k]),
            .i_rat_busy(w_rat_busy2[k]), .i_commit_valid(commit_valid),
            .i_commit_tag(commit_tag), .o_tag(w_rs2_tag[k]), .o_busy(w_rs2_busy[k])
        );
    end

    // Commit clears first so a same-cycle rename of that register overrides it.
    always_comb begin
        w_busy_nxt = r_rat_busy;
        w_tag_nxt  = r_rat_tag;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int p = 0; p < COMMIT_PORTS; p++) begin
                if (commit_valid[p] && r_rat_busy[commit_rd[p]] &&
                    r_rat_tag[commit_rd[p]] == commit_tag[p])
                    w_busy_nxt[commit_rd[p]] = 1'b0;
            end
            for (int k = 0; k < WIDTH; k++) begin
                if (w_slot_vld[k] && w_s_has_rd[k] && w_s_rd[k] != '0) begin
                    w_tag_nxt[w_s_rd[k]]  = rob_tags[k];
                    w_busy_nxt[w_s_rd[k]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rat_busy <= '0;
            for (int r = 0; r < ARCH_REGS; r++)
                r_rat_tag[r] <= '0;
        end else begin
            r_rat_busy <= w_busy_nxt;
            r_rat_tag  <= w_tag_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_done_cnt <= '0;
        else if (flush || in_ready)
            r_done_cnt <= '0;
        else if (w_accept)
            r_done_cnt <= r_done_cnt + w_g;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid    <= '0;
            r_out_rs1_tag  <= '0;
            r_out_rs2_tag  <= '0;
            r_out_rs1_busy <= '0;
            r_out_rs2_busy <= '0;
            r_out_dest_tag <= '0;
            r_out_payload  <= '0;
        end else if (flush) begin
            r_out_valid <= '0;
        end else if (w_accept) begin
            r_out_valid <= w_slot_vld;
            for (int k = 0; k < WIDTH; k++) begin
                r_out_rs1_tag[k]  <= w_slot_vld[k] ? w_rs1_tag[k]   : '0;
                r_out_rs2_tag[k]  <= w_slot_vld[k] ? w_rs2_tag[k]   : '0;
                r_out_rs1_busy[k] <= w_slot_vld[k] && w_rs1_busy[k];
                r_out_rs2_busy[k] <= w_slot_vld[k] && w_rs2_busy[k];
                r_out_dest_tag[k] <= w_slot_vld[k] ? rob_tags[k]    : '0;
                r_out_payload[k]  <= w_slot_vld[k] ? w_s_payload[k] : '0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_rs1_tag  = r_out_rs1_tag;
    assign out_rs2_tag  = r_out_rs2_tag;
    assign out_rs1_busy = r_out_rs1_busy;
    assign out_rs2_busy = r_out_rs2_busy;
    assign out_dest_tag = r_out_dest_tag;
    assign out_payload  = r_out_payload;
endmodule

// File: tb/tb_rename_n.sv
// Directed bench for rename_n (WIDTH=2): hand-computed expectations for
// grant, forwarding, partial grant, commit, back-pressure, flush and reset.
module tb_rename_n;
    localparam int W  = 2;
    localparam int AW = 5;
    localparam int TW = 6;
    localparam int CP = 2;
    localparam int PW = 64;
    localparam int CW = 2;

    logic                   clk, rst, flush;
    logic [W-1:0]           in_valid;
    logic                   in_ready;
    logic [W-1:0][AW-1:0]   in_rs1, in_rs2, in_rd;
    logic [W-1:0]           in_has_rd;
    logic [W-1:0][PW-1:0]   in_payload;
    logic [CW-1:0]          rob_alloc_req, rob_alloc_gnt;
    logic [W-1:0][TW-1:0]   rob_tags;
    logic [CP-1:0]          commit_valid;
    logic [CP-1:0][AW-1:0]  commit_rd;
    logic [CP-1:0][TW-1:0]  commit_tag;
    logic [W-1:0]           out_valid;
    logic                   out_ready;
    logic [W-1:0][TW-1:0]   out_rs1_tag, out_rs2_tag, out_dest_tag;
    logic [W-1:0]           out_rs1_busy, out_rs2_busy;
    logic [W-1:0][PW-1:0]   out_payload;

    int n_chk = 0;
    int n_err = 0;

    rename_n #(.WIDTH(W), .ARCH_REGS(32), .TAG_WIDTH(TW), .COMMIT_PORTS(CP), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_has_rd(in_has_rd), .in_payload(in_payload),
        .rob_alloc_req(rob_alloc_req), .rob_alloc_gnt(rob_alloc_gnt), .rob_tags(rob_tags),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_tag(out_rs1_tag), .out_rs2_tag(out_rs2_tag),
        .out_rs1_busy(out_rs1_busy), .out_rs2_busy(out_rs2_busy),
        .out_dest_tag(out_dest_tag), .out_payload(out_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic lane(input int l, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic hrd);
        in_rs1[l]    = rs1;
        in_rs2[l]    = rs2;
        in_rd[l]     = rd;
        in_has_rd[l] = hrd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_has_rd = '0; in_payload = '0; rob_alloc_gnt = '0; rob_tags = '0;
        commit_valid = '0; commit_rd = '0; commit_tag = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dest", out_dest_tag, 0);
        chk("rst_payload", out_payload, 0);
        chk("rst_req", rob_alloc_req, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b1;

        // full grant, no dependencies
        lane(0, 1, 2, 5, 1); lane(1, 3, 4, 6, 1); in_valid = 2'b11;
        in_payload[0] = 64'hA0; in_payload[1] = 64'hA1;
        rob_alloc_gnt = 2; rob_tags[0] = 3; rob_tags[1] = 4;
        #1;
        chk("full_req", rob_alloc_req, 2);
        chk("full_in_ready", in_ready, 1);
        tick();
        chk("full_out_valid", out_valid, 2'b11);
        chk("full_dest", out_dest_tag, {6'd4, 6'd3});
        chk("full_payload", out_payload, {64'hA1, 64'hA0});
        chk("full_rs1_busy", out_rs1_busy, 0);

        lane(0, 5, 6, 0, 0); lane(1, 0, 0, 0, 0); in_valid = 2'b01;
        rob_alloc_gnt = 1; rob_tags[0] = 7;
        #1;
        chk("look_req", rob_alloc_req, 1);
        tick();
        chk("look_valid", out_valid, 2'b01);
        chk("rat_x5", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b1, 6'd3});
        chk("rat_x6", {out_rs2_busy[0], out_rs2_tag[0]}, {1'b1, 6'd4});

        // intra-group dependency
        lane(0, 0, 0, 7, 1); lane(1, 7, 0, 7, 1); in_valid = 2'b11;
        rob_alloc_gnt = 2; rob_tags[0] = 8; rob_tags[1] = 9;
        tick();
        chk("dep_rs1_busy", out_rs1_busy, 2'b10);
        chk("dep_rs1_tag", out_rs1_tag[1], 8);
        chk("dep_rs2", {out_rs2_busy[1], out_rs2_tag[1]}, 0);
        lane(0, 7, 0, 0, 0); in_valid = 2'b01; rob_alloc_gnt = 1; rob_tags[0] = 10;
        tick();
        chk("dep_rat_x7", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b1, 6'd9});

        // partial grant
        lane(0, 0, 0, 8, 1); lane(1, 8, 0, 9, 1); in_valid = 2'b11;
        in_payload[0] = 64'hB0; in_payload[1] = 64'hB1;
        rob_alloc_gnt = 1; rob_tags[0] = 10;
        #1;
        chk("part_req", rob_alloc_req, 2);
        chk("part_in_ready", in_ready, 0);
        tick();
        chk("part_valid", out_valid, 2'b01);
        chk("part_dest", out_dest_tag[0], 10);
        chk("part_req2", rob_alloc_req, 1);
        rob_tags[0] = 11;
        #1;
        chk("part_in_ready2", in_ready, 1);
        tick();
        chk("part2_valid", out_valid, 2'b01);
        chk("part2_dest", out_dest_tag[0], 11);
        chk("part2_payload", out_payload[0], 64'hB1);
        chk("part2_rs1", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b1, 6'd10});

        // commit bypass, clear, stale commit, commit vs rename
        lane(0, 5, 0, 0, 0); lane(1, 0, 0, 0, 0); in_valid = 2'b01;
        rob_alloc_gnt = 1; rob_tags[0] = 12;
        commit_valid = 2'b01; commit_rd[0] = 5; commit_tag[0] = 3;
        tick();
        chk("cmt_bypass", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b0, 6'd3});
        commit_valid = '0;
        tick();
        chk("cmt_cleared", out_rs1_busy[0], 0);
        lane(0, 6, 0, 0, 0);
        commit_valid = 2'b01; commit_rd[0] = 6; commit_tag[0] = 2;
        tick();
        chk("cmt_stale", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b1, 6'd4});
        commit_valid = '0;
        tick();
        chk("cmt_stale_rat", out_rs1_busy[0], 1);
        lane(0, 6, 0, 6, 1); rob_tags[0] = 13;
        commit_valid = 2'b01; commit_rd[0] = 6; commit_tag[0] = 4;
        tick();
        chk("cmt_ren_bypass", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b0, 6'd4});
        commit_valid = '0; lane(0, 6, 0, 0, 0); rob_tags[0] = 14;
        tick();
        chk("cmt_ren_rat", {out_rs1_busy[0], out_rs1_tag[0]}, {1'b1, 6'd13});

        // back-pressure
        out_ready = 1'b0; lane(0, 1, 2, 0, 0); lane(1, 3, 4, 0, 0); in_valid = 2'b11;
        rob_alloc_gnt = 0;
        #1;
        chk("bp_req", rob_alloc_req, 0);
        chk("bp_in_ready", in_ready, 0);
        tick();
        chk("bp_hold_valid", out_valid, 2'b01);
        chk("bp_hold_dest", out_dest_tag[0], 14);
        out_ready = 1'b1; rob_alloc_gnt = 2; rob_tags[0] = 20; rob_tags[1] = 21;
        #1;
        chk("bp_resume_req", rob_alloc_req, 2);
        chk("bp_resume_ready", in_ready, 1);
        tick();
        chk("bp_resume_valid", out_valid, 2'b11);
        chk("bp_resume_dest", out_dest_tag, {6'd21, 6'd20});

        // flush in the middle of a partially granted group
        lane(0, 0, 0, 5, 1); lane(1, 0, 0, 6, 1); rob_alloc_gnt = 1; rob_tags[0] = 22;
        tick();
        chk("fl_part_valid", out_valid, 2'b01);
        flush = 1'b1; rob_alloc_gnt = 0;
        #1;
        chk("fl_req", rob_alloc_req, 0);
        chk("fl_in_ready", in_ready, 0);
        tick();
        chk("fl_out_valid", out_valid, 0);
        flush = 1'b0; lane(0, 5, 6, 0, 0); lane(1, 0, 0, 0, 0);
        #1;
        chk("fl_done_cnt", rob_alloc_req, 2);
        rob_alloc_gnt = 2; rob_tags[0] = 30; rob_tags[1] = 31;
        tick();
        chk("fl_valid_after", out_valid, 2'b11);
        chk("fl_busy_clr", {out_rs1_busy, out_rs2_busy}, 0);
        chk("fl_tag_kept", out_rs1_tag[0], 22);

        // asynchronous reset mid-stream
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_dest", out_dest_tag, 0);
        chk("arst_payload", out_payload, 0);
        chk("arst_rs1_tag", out_rs1_tag, 0);
        #3;
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
